// File: rtl/mul_div_seq.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes) with HI/LO result registers.
// Optional build macro MULDIV_FAST_ZERO_EN: zero-operand short path (done one cycle after start).
module mul_div_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] HI,
    output logic [DATA_WIDTH-1:0] LO,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W:0]       acc_q, acc_d;
    logic [W-1:0]     mq_q, mq_d;
    logic             qm1_q, qm1_d;
    logic [W-1:0]     m_q, m_d;
    logic             op_q, op_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [W-1:0]     a_mag, b_mag;
    logic [W:0]       m_ext;
    logic [W:0]       booth_sum;
    logic [W:0]       div_shift;
    logic [W+1:0]     div_diff;
    logic             fast_zero;

    assign a_mag = A[W-1] ? -A : A;
    assign b_mag = B[W-1] ? -B : B;
    assign m_ext = {m_q[W-1], m_q};

`ifdef MULDIV_FAST_ZERO_EN
    assign fast_zero = op ? (A == '0) : ((A == '0) || (B == '0));
`else
    assign fast_zero = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        qm1_d     = qm1_q;
        m_d       = m_q;
        op_d      = op_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dz_d      = dz_q;
        booth_sum = acc_q;
        div_shift = {acc_q[W-1:0], mq_q[W-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, m_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    sa_d  = A[W-1];
                    sb_d  = B[W-1];
                    cnt_d = '0;
                    acc_d = '0;
                    qm1_d = 1'b0;
                    // MUL keeps signed operands; DIV works on magnitudes, signs fixed in FIX.
                    m_d   = op ? b_mag : A;
                    mq_d  = op ? a_mag : B;
                    if (op && (B == '0)) begin
                        state_d = S_DONE;
                        hi_d    = A;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                    end else if (fast_zero) begin
                        state_d = S_DONE;
                        hi_d    = '0;
                        lo_d    = '0;
                        dz_d    = 1'b0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!op_q) begin
                    case ({mq_q[0], qm1_q})
                        2'b01:   booth_sum = acc_q + m_ext;
                        2'b10:   booth_sum = acc_q - m_ext;
                        default: booth_sum = acc_q;
                    endcase
                    acc_d = {booth_sum[W], booth_sum[W:1]};
                    mq_d  = {booth_sum[0], mq_q[W-1:1]};
                    qm1_d = mq_q[0];
                end else if (!div_diff[W+1]) begin
                    acc_d = div_diff[W:0];
                    mq_d  = {mq_q[W-2:0], 1'b1};
                end else begin
                    acc_d = div_shift;
                    mq_d  = {mq_q[W-2:0], 1'b0};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FIX: begin
                if (!op_q) begin
                    hi_d = acc_q[W-1:0];
                    lo_d = mq_q;
                end else begin
                    lo_d = (sa_q ^ sb_q) ? -mq_q : mq_q;
                    hi_d = sa_q ? -acc_q[W-1:0] : acc_q[W-1:0];
                end
                dz_d    = 1'b0;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            op_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            op_q    <= op_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign HI       = hi_q;
    assign LO       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_mul_div_seq.sv
// Bench for mul_div_seq: directed vector table, hand-written multi-cycle sequences, random ops vs. arithmetic model.
module tb_mul_div_seq;
    localparam int N = 32;
`ifdef MULDIV_FAST_ZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 34;
`endif

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic          op;
    logic [N-1:0]  A, B;
    logic [N-1:0]  HI, LO;
    logic          busy, done, div_zero;

    int total = 0;
    int bad   = 0;

    mul_div_seq #(.DATA_WIDTH(N)) dut (
        .clock(clock), .clear(clear), .start(start), .op(op), .A(A), .B(B),
        .HI(HI), .LO(LO), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain signed 64-bit arithmetic; SV division truncates toward zero.
    function automatic void model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo,
                                  output logic dz, output int lat);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        if (!o) begin
            p   = sa * sb;
            hi  = p[63:32];
            lo  = p[31:0];
            lat = (a == 0 || b == 0) ? ZLAT : 34;
        end else if (b == 0) begin
            hi  = a;
            lo  = 32'hFFFF_FFFF;
            dz  = 1'b1;
            lat = 1;
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            lo  = q[31:0];
            hi  = r[31:0];
            lat = (a == 0) ? ZLAT : 34;
        end
    endfunction

    // Issues one op, measures done latency and checks busy over cycles 1..done.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo,
                          output logic dz, output int lat, output bit busy_ok, output bit post_ok);
        lat = 0; busy_ok = 1'b1; post_ok = 1'b0;
        hi = '0; lo = '0; dz = 1'b0;
        @(negedge clock);
        start = 1'b1; op = o; A = a; B = b;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clock);
            if (k == 1) begin
                start = 1'b0; op = 1'($urandom); A = $urandom; B = $urandom;
            end
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = k; hi = HI; lo = LO; dz = div_zero;
                break;
            end
        end
        @(negedge clock);
        post_ok = (done == 1'b0) && (busy == 1'b0) && (HI == hi) && (LO == lo) && (div_zero == dz);
    endtask

    task automatic check_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input int elat);
        logic [31:0] hi, lo;
        logic        dz;
        int          lat;
        bit          bok, pok;
        run_op(o, a, b, hi, lo, dz, lat, bok, pok);
        $display("op=%0d A=%h B=%h -> HI=%h LO=%h dz=%0d lat=%0d (%s)", o, a, b, hi, lo, dz, lat, tag);
        chk({tag, ".hi"}, 64'(hi), 64'(ehi));
        chk({tag, ".lo"}, 64'(lo), 64'(elo));
        chk({tag, ".dz"}, 64'(dz), 64'(edz));
        chk({tag, ".lat"}, 64'(lat), 64'(elat));
        chk({tag, ".busy"}, 64'(bok), 64'(1));
        chk({tag, ".post"}, 64'(pok), 64'(1));
    endtask

    vec_t vecs[12];

    initial begin
        logic [31:0] mhi, mlo;
        logic        mdz;
        int          mlat;
        int          n_done, first_k, second_k;

        vecs[0]  = '{1'b0, 32'd5,          32'd3,          32'h0000_0000, 32'h0000_000F, 1'b0, 34};
        vecs[1]  = '{1'b0, 32'd5,          32'hFFFF_FFFE,  32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b0, 34};
        vecs[2]  = '{1'b0, 32'h7FFF_FFFF,  32'd2,          32'h0000_0000, 32'hFFFF_FFFE, 1'b0, 34};
        vecs[3]  = '{1'b0, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0, 34};
        vecs[4]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0, 34};
        vecs[6]  = '{1'b1, 32'd100,        32'd0,          32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1};
        vecs[7]  = '{1'b0, 32'd0,          32'd12345,      32'h0000_0000, 32'h0000_0000, 1'b0, ZLAT};
        vecs[8]  = '{1'b1, 32'd0,          32'd7,          32'h0000_0000, 32'h0000_0000, 1'b0, ZLAT};
        vecs[9]  = '{1'b0, 32'h0000_1234,  32'd0,          32'h0000_0000, 32'h0000_0000, 1'b0, ZLAT};
        vecs[10] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[11] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001, 1'b0, 34};

        clear = 1'b0; start = 1'b0; op = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clock);
        chk("reset.hi", 64'(HI), 64'(0));
        chk("reset.lo", 64'(LO), 64'(0));
        chk("reset.flags", {61'd0, busy, done, div_zero}, 64'(0));
        clear = 1'b1;

        for (int i = 0; i < 12; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                     vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].lat);
        end

        // start held high: one done at 34, re-accept only once back in IDLE (edge 35 -> done 69).
        @(negedge clock);
        start = 1'b1; op = 1'b0; A = 32'd6; B = 32'd7;
        n_done = 0; first_k = 0; second_k = 0;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clock);
            if (k == 41) start = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    first_k = k;
                    chk("hold.lo", 64'(LO), 64'd42);
                    chk("hold.hi", 64'(HI), 64'd0);
                end else if (n_done == 2) begin
                    second_k = k;
                end
            end
        end
        $display("hold start: dones=%0d first=%0d second=%0d", n_done, first_k, second_k);
        chk("hold.ndone", 64'(n_done), 64'd2);
        chk("hold.first", 64'(first_k), 64'd34);
        chk("hold.second", 64'(second_k), 64'd69);

        // Divide by zero sets div_zero, which must persist into the next op until reset aborts it.
        check_op("dz_pre", 1'b1, 32'd100, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b1, 1);
        @(negedge clock);
        start = 1'b1; op = 1'b0; A = 32'd5; B = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 1) start = 1'b0;
            if (k == 5) chk("abort.dz_held", {62'd0, busy, div_zero}, 64'b11);
            if (k == 10) clear = 1'b0;
        end
        @(negedge clock);
        $display("abort: busy=%0d done=%0d HI=%h LO=%h dz=%0d", busy, done, HI, LO, div_zero);
        chk("abort.flags", {61'd0, busy, done, div_zero}, 64'(0));
        chk("abort.hilo", {HI, LO}, 64'(0));
        clear = 1'b1;
        model(1'b0, 32'h1234_5678, 32'hFFFF_FFFD, mhi, mlo, mdz, mlat);
        check_op("after_abort", 1'b0, 32'h1234_5678, 32'hFFFF_FFFD, mhi, mlo, mdz, mlat);

        for (int i = 0; i < 40; i++) begin
            logic        o;
            logic [31:0] a, b;
            o = 1'($urandom);
            a = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            b = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 20);
            model(o, a, b, mhi, mlo, mdz, mlat);
            check_op($sformatf("rand%0d", i), o, a, b, mhi, mlo, mdz, mlat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
